sram_test: RTL and testbench

SRAM_TEST -- requirements
Module: sram_test

---
 rtl/sram_test_if.sv | 27 ++
 rtl/sram_test.sv | 198 +++++++++++++++++++
 tb/tb_sram_test.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_test_if.sv
// SRAM pin bundle: address, split data in/out with output enable, and
// the three active-low strobes. The tester is the master; the SRAM
// (or its model) is the slave.
interface sram_test_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_dataOut;
    logic [DATA_WIDTH-1:0] sram_dataIn;
    logic                  sram_dataOe;
    logic                  sram_nCE;
    logic                  sram_nWE;
    logic                  sram_nOE;

    modport master (
        output sram_addr, sram_dataOut, sram_dataOe,
               sram_nCE, sram_nWE, sram_nOE,
        input  sram_dataIn
    );

    modport slave (
        input  sram_addr, sram_dataOut, sram_dataOe,
               sram_nCE, sram_nWE, sram_nOE,
        output sram_dataIn
    );
endinterface

// File: rtl/sram_test.sv
// Full-array SRAM tester: writes an address-derived pattern to every word,
// reads it back and compares, then repeats with the pattern inverted.
// Reports pass/fail and the first failing address. Every output comes
// straight from a flop; output flops are loaded from the next-state value
// so they line up with the state they describe.
module sram_test #(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  sysClock,
    input  logic                  sysReset,
    input  logic                  start,
    sram_test_if.master           sram,
    output logic                  busy,
    output logic [1:0]            test_result,
    output logic [ADDR_WIDTH-1:0] fail_addr
);
    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_STROBE, S_W_HOLD,
        S_R_SETUP, S_R_STROBE, S_COMPARE, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [3:0]            CNT_LAST  = 4'(WAIT_CYCLES - 1);
    localparam logic [1:0]            RES_RUN   = 2'b00;
    localparam logic [1:0]            RES_PASS  = 2'b01;
    localparam logic [1:0]            RES_FAIL  = 2'b10;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inv_q, inv_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [1:0]            result_q, result_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  oe_q, oe_d;
    logic                  nce_q, nce_d;
    logic                  nwe_q, nwe_d;
    logic                  noe_q, noe_d;
    logic                  busy_q, busy_d;

    // Pattern for the upcoming word (write data) and for the current word
    // (compare reference): address zero-extended or truncated, XOR inv.
    logic [DATA_WIDTH-1:0] pat_d, pat_q;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_pat
            if (gi < ADDR_WIDTH) begin : g_addr_bit
                assign pat_d[gi] = addr_d[gi] ^ inv_d;
                assign pat_q[gi] = addr_q[gi] ^ inv_q;
            end else begin : g_pad_bit
                assign pat_d[gi] = inv_d;
                assign pat_q[gi] = inv_q;
            end
        end
    endgenerate

    // Sequencer: walks write/read phases over every address, times strobes,
    // captures read data and decides pass/fail.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inv_d     = inv_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        result_d  = result_q;
        fail_d    = fail_q;
        case (state_q)
            S_IDLE: begin
                state_d  = S_W_SETUP;
                addr_d   = '0;
                inv_d    = 1'b0;
                result_d = RES_RUN;
            end
            S_W_SETUP: begin
                state_d = S_W_STROBE;
                cnt_d   = '0;
            end
            S_W_STROBE: begin
                if (cnt_q == CNT_LAST) state_d = S_W_HOLD;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_W_HOLD: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    state_d = S_R_SETUP;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_W_SETUP;
                end
            end
            S_R_SETUP: begin
                state_d = S_R_STROBE;
                cnt_d   = '0;
            end
            S_R_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    rd_data_d = sram.sram_dataIn;
                    state_d   = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_COMPARE: begin
                if (rd_data_q != pat_q) begin
                    fail_d   = addr_q;
                    result_d = RES_FAIL;
                    state_d  = S_DONE;
                end else if (addr_q == ADDR_LAST) begin
                    if (inv_q) begin
                        result_d = RES_PASS;
                        state_d  = S_DONE;
                    end else begin
                        addr_d  = '0;
                        inv_d   = 1'b1;
                        state_d = S_W_SETUP;
                    end
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_R_SETUP;
                end
            end
            S_DONE: begin
                if (start) begin
                    result_d = RES_RUN;
                    fail_d   = '0;
                    addr_d   = '0;
                    inv_d    = 1'b0;
                    state_d  = S_W_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin levels for the state being entered, so the registered pins match it.
    always_comb begin
        oe_d   = 1'b0;
        nce_d  = 1'b0;
        nwe_d  = 1'b1;
        noe_d  = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            S_W_SETUP:  oe_d = 1'b1;
            S_W_STROBE: begin oe_d = 1'b1; nwe_d = 1'b0; end
            S_W_HOLD:   oe_d = 1'b1;
            S_R_STROBE: noe_d = 1'b0;
            S_IDLE, S_DONE: begin nce_d = 1'b1; busy_d = 1'b0; end
            default: ;
        endcase
    end

    // State and output registers; reset takes effect immediately.
    always_ff @(posedge sysClock or posedge sysReset) begin
        if (sysReset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            inv_q     <= 1'b0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            result_q  <= RES_RUN;
            fail_q    <= '0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            nce_q     <= 1'b1;
            nwe_q     <= 1'b1;
            noe_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inv_q     <= inv_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            result_q  <= result_d;
            fail_q    <= fail_d;
            dout_q    <= pat_d;
            oe_q      <= oe_d;
            nce_q     <= nce_d;
            nwe_q     <= nwe_d;
            noe_q     <= noe_d;
            busy_q    <= busy_d;
        end
    end

    assign sram.sram_addr    = addr_q;
    assign sram.sram_dataOut = dout_q;
    assign sram.sram_dataOe  = oe_q;
    assign sram.sram_nCE     = nce_q;
    assign sram.sram_nWE     = nwe_q;
    assign sram.sram_nOE     = noe_q;
    assign busy              = busy_q;
    assign test_result       = result_q;
    assign fail_addr         = fail_q;
endmodule

// File: tb/tb_sram_test.sv
// Bench for sram_test with a 16x8 SRAM model, optional stuck-at-0 fault on
// bit 3 of word 5, a transaction-level expectation queue and per-cycle
// strobe checks.
module tb_sram_test;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int WC = 2;

    logic          sysClock = 1'b0;
    logic          sysReset;
    logic          start;
    logic          busy;
    logic [1:0]    test_result;
    logic [AW-1:0] fail_addr;

    sram_test_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_test #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
        .sysClock    (sysClock),
        .sysReset    (sysReset),
        .start       (start),
        .sram        (bus),
        .busy        (busy),
        .test_result (test_result),
        .fail_addr   (fail_addr)
    );

    always #5 sysClock = ~sysClock;

    // SRAM model
    logic [DW-1:0] mem [16];
    logic          fault_en;
    logic [DW-1:0] rd_mask;

    always @(posedge sysClock)
        if (!bus.sram_nCE && !bus.sram_nWE && bus.sram_dataOe)
            mem[bus.sram_addr] <= bus.sram_dataOut;

    assign rd_mask = (fault_en && bus.sram_addr == 4'd5) ? 8'hF7 : 8'hFF;
    assign bus.sram_dataIn = (!bus.sram_nCE && !bus.sram_nOE) ?
                             (mem[bus.sram_addr] & rd_mask) : 8'hA5;

    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: expected word transactions and run outcome.
    typedef struct {
        bit wr;
        bit inv;
        int addr;
        int data;
    } txn_t;

    txn_t exp_q[$];
    int   exp_busy;
    int   exp_result;
    int   exp_fail;

    function automatic logic [DW-1:0] pat(input int a, input bit inv);
        logic [31:0] a32;
        a32 = a;
        return a32[DW-1:0] ^ {DW{inv}};
    endfunction

    task automatic build_model(input bit fault);
        txn_t t;
        logic [DW-1:0] rd;
        exp_q.delete();
        exp_busy   = 0;
        exp_result = 1;
        exp_fail   = 0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int a = 0; a < 16; a++) begin
                exp_busy += WC + 2;
                t.wr   = (ph % 2 == 0);
                t.inv  = (ph >= 2);
                t.addr = a;
                t.data = int'(pat(a, t.inv));
                exp_q.push_back(t);
                if (!t.wr) begin
                    rd = pat(a, t.inv);
                    if (fault && a == 5) rd = rd & 8'hF7;
                    if (rd != pat(a, t.inv)) begin
                        exp_result = 2;
                        exp_fail   = a;
                        return;
                    end
                end
            end
        end
    endtask

    // Compare process: strobe shape per cycle, word transactions vs model.
    int            busy_cycles = 0;
    int            wlen, rlen;
    logic          prev_nwe, prev_noe, prev_oe, prev_nce;
    logic [AW-1:0] prev_addr, w_addr, r_addr;
    logic [DW-1:0] prev_dout, w_data;
    logic [DW-1:0] f_write_ph1 = '0;

    always @(negedge sysClock) begin
        txn_t t;
        if (sysReset) begin
            wlen = 0; rlen = 0;
            prev_nwe = 1'b1; prev_noe = 1'b1; prev_oe = 1'b0; prev_nce = 1'b1;
            prev_addr = '0; prev_dout = '0;
        end else begin
            if (busy) busy_cycles++;
            check("strobe_overlap", 32'(!bus.sram_nWE && !bus.sram_nOE), 0);
            if (!bus.sram_nOE) check("oe_during_read", 32'(bus.sram_dataOe), 0);
            // write strobe
            if (!bus.sram_nWE) begin
                if (wlen == 0) begin
                    check("w_setup_addr", 32'(bus.sram_addr), 32'(prev_addr));
                    check("w_setup_data", 32'(bus.sram_dataOut), 32'(prev_dout));
                    check("w_setup_oe", 32'(prev_oe), 1);
                    check("w_setup_nce", 32'(prev_nce), 0);
                    w_addr = bus.sram_addr;
                    w_data = bus.sram_dataOut;
                end else begin
                    check("w_strobe_addr", 32'(bus.sram_addr), 32'(w_addr));
                    check("w_strobe_data", 32'(bus.sram_dataOut), 32'(w_data));
                end
                wlen++;
            end else if (!prev_nwe) begin
                check("w_len", wlen, WC);
                check("w_hold_addr", 32'(bus.sram_addr), 32'(w_addr));
                check("w_hold_data", 32'(bus.sram_dataOut), 32'(w_data));
                check("w_hold_oe", 32'(bus.sram_dataOe), 1);
                if (exp_q.size() == 0) check("exp_underflow", 1, 0);
                else begin
                    t = exp_q.pop_front();
                    check("w_kind", 1, 32'(t.wr));
                    check("w_addr", 32'(w_addr), t.addr);
                    check("w_data", 32'(w_data), t.data);
                    if (t.inv && t.addr == 15) f_write_ph1 = w_data;
                end
                wlen = 0;
            end
            // read strobe
            if (!bus.sram_nOE) begin
                if (rlen == 0) begin
                    check("r_setup_addr", 32'(bus.sram_addr), 32'(prev_addr));
                    check("r_setup_nce", 32'(prev_nce), 0);
                    r_addr = bus.sram_addr;
                end else begin
                    check("r_strobe_addr", 32'(bus.sram_addr), 32'(r_addr));
                end
                rlen++;
            end else if (!prev_noe) begin
                check("r_len", rlen, WC);
                if (exp_q.size() == 0) check("exp_underflow", 1, 0);
                else begin
                    t = exp_q.pop_front();
                    check("r_kind", 0, 32'(t.wr));
                    check("r_addr", 32'(r_addr), t.addr);
                end
                rlen = 0;
            end
            prev_nwe  = bus.sram_nWE;
            prev_noe  = bus.sram_nOE;
            prev_oe   = bus.sram_dataOe;
            prev_nce  = bus.sram_nCE;
            prev_addr = bus.sram_addr;
            prev_dout = bus.sram_dataOut;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, 32'(bus.sram_addr), 0);
        check({tag, "_dout"}, 32'(bus.sram_dataOut), 0);
        check({tag, "_oe"}, 32'(bus.sram_dataOe), 0);
        check({tag, "_nce"}, 32'(bus.sram_nCE), 1);
        check({tag, "_nwe"}, 32'(bus.sram_nWE), 1);
        check({tag, "_noe"}, 32'(bus.sram_nOE), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_result"}, 32'(test_result), 0);
        check({tag, "_fail_addr"}, 32'(fail_addr), 0);
    endtask

    task automatic run_to_done(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge sysClock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sysClock);
        start = 1'b0;
    endtask

    int b0;

    initial begin
        sysReset = 1'b1;
        start    = 1'b0;
        fault_en = 1'b0;
        repeat (3) @(negedge sysClock);
        check_reset_values("rst");

        // Run 1: ideal SRAM, auto-start after reset release
        build_model(1'b0);
        b0 = busy_cycles;
        sysReset = 1'b0;
        @(negedge sysClock);
        check("auto_start_busy", 32'(busy), 1);
        check("auto_start_result", 32'(test_result), 0);
        check("auto_start_addr", 32'(bus.sram_addr), 0);
        run_to_done(2000);
        check("ideal_busy_model", busy_cycles - b0, exp_busy);
        check("ideal_busy_lit", busy_cycles - b0, 256);
        check("ideal_result", 32'(test_result), exp_result);
        check("ideal_result_lit", 32'(test_result), 1);
        check("ideal_fail_addr", 32'(fail_addr), exp_fail);
        check("ideal_drained", exp_q.size(), 0);
        check("trunc_write_f_ph1", 32'(f_write_ph1), 32'h0000_00F0);
        $display("run ideal: busy=%0d result=%0d", busy_cycles - b0, test_result);

        // Run 2: stuck-at-0 on bit 3 of word 5
        fault_en = 1'b1;
        build_model(1'b1);
        b0 = busy_cycles;
        pulse_start();
        check("restart_busy", 32'(busy), 1);
        check("restart_addr", 32'(bus.sram_addr), 0);
        run_to_done(2000);
        check("fault_busy_model", busy_cycles - b0, exp_busy);
        check("fault_busy_lit", busy_cycles - b0, 216);
        check("fault_result", 32'(test_result), exp_result);
        check("fault_result_lit", 32'(test_result), 2);
        check("fault_addr_model", 32'(fail_addr), exp_fail);
        check("fault_addr_lit", 32'(fail_addr), 5);
        check("fault_drained", exp_q.size(), 0);
        $display("run fault: busy=%0d result=%0d fail_addr=%0d", busy_cycles - b0, test_result, fail_addr);

        // Run 3: restart from fail state, then a start pulse while busy
        fault_en = 1'b0;
        build_model(1'b0);
        b0 = busy_cycles;
        pulse_start();
        check("clear_result", 32'(test_result), 0);
        check("clear_fail_addr", 32'(fail_addr), 0);
        check("clear_busy", 32'(busy), 1);
        check("clear_addr", 32'(bus.sram_addr), 0);
        repeat (50) @(negedge sysClock);
        pulse_start();
        run_to_done(2000);
        check("busy_start_ignored", busy_cycles - b0, 256);
        check("busy_start_result", 32'(test_result), 1);
        check("busy_start_drained", exp_q.size(), 0);
        $display("run start-while-busy: busy=%0d result=%0d", busy_cycles - b0, test_result);

        // Run 4: async reset during R_STROBE of read phase 1 (word 3)
        build_model(1'b0);
        pulse_start();
        repeat (205) @(negedge sysClock);
        check("pre_rst_noe", 32'(bus.sram_nOE), 0);
        check("pre_rst_addr", 32'(bus.sram_addr), 3);
        #1 sysReset = 1'b1;
        #1 check_reset_values("async_rst");
        repeat (2) @(negedge sysClock);
        build_model(1'b0);
        b0 = busy_cycles;
        sysReset = 1'b0;
        @(negedge sysClock);
        check("post_rst_busy", 32'(busy), 1);
        check("post_rst_addr", 32'(bus.sram_addr), 0);
        check("post_rst_dout", 32'(bus.sram_dataOut), 0);
        run_to_done(2000);
        check("post_rst_busy_cycles", busy_cycles - b0, 256);
        check("post_rst_result", 32'(test_result), 1);
        check("post_rst_drained", exp_q.size(), 0);
        $display("run after reset: busy=%0d result=%0d", busy_cycles - b0, test_result);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
